seq_divider: RTL and testbench

Multi-cycle unsigned integer divider that inverts the adder datapath: it produces quotient and remainder by repeated trial subtraction through a carry-lookahead add/subtract unit, one quotient bit per clock. It sits beside the CLA adder blocks in the ALU datapath and is driven by a simple start/done handshake from the control unit.

---
 rtl/div_pkg.sv | 27 ++
 rtl/cla_addsub.sv | 59 +++++
 rtl/seq_divider.sv | 138 +++++++++++++
 tb/tb_seq_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types and constants for the sequential divider.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int C_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_addsub.sv
// ============================================================================
//  Module   : cla_addsub
//  Purpose  : Add/subtract unit from 4-bit carry-lookahead groups plus one
//             single-bit generate/propagate cell on top.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_addsub #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int C_NGRP = (WIDTH - 1) / 4;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [C_NGRP:0]  w_gc;

  assign w_b     = b ^ {WIDTH{sub}};
  assign w_p     = a ^ w_b;
  assign w_g     = a & w_b;
  assign w_gc[0] = sub;

  for (genvar gi = 0; gi < C_NGRP; gi++) begin : g_grp
    logic [3:0] w_gp;
    logic [3:0] w_gg;
    logic [3:0] w_c;
    logic       w_grp_g;
    logic       w_grp_p;

    assign w_gp   = w_p[4*gi +: 4];
    assign w_gg   = w_g[4*gi +: 4];
    assign w_c[0] = w_gc[gi];
    assign w_c[1] = w_gg[0] | (w_gp[0] & w_c[0]);
    assign w_c[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_c[0]);
    assign w_c[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & w_c[0]);

    assign w_grp_g = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
    assign w_grp_p = &w_gp;

    assign w_gc[gi+1]       = w_grp_g | (w_grp_p & w_c[0]);
    assign sum[4*gi +: 4]   = w_gp ^ w_c;
  end

  assign sum[WIDTH-1] = w_p[WIDTH-1] ^ w_gc[C_NGRP];
  assign cout         = w_g[WIDTH-1] | (w_p[WIDTH-1] & w_gc[C_NGRP]);

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Restoring unsigned divider, one quotient bit per clock.
//             Optional build macro DIVZERO_DETECT_EN short-cuts divide-by-zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int C_CNT_W = clog2(WIDTH);

  div_state_t       r_state;
  div_state_t       w_next;
  div_state_t       w_start_dst;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic [C_CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_t;
  logic             w_cout;
  logic             w_take;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_rem_nxt;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == '0);

  assign w_s = {r_rem, r_q[WIDTH-1]};

  cla_addsub #(
    .WIDTH (WIDTH + 1)
  ) u_addsub (
    .a    (w_s),
    .b    ({1'b0, r_dvsr}),
    .sub  (1'b1),
    .sum  (w_t),
    .cout (w_cout)
  );

  // Since S < 2*divisor, the sign bit of T and the carry-out always agree.
  assign w_take    = ~w_t[WIDTH] & w_cout;
  assign w_q_nxt   = {r_q[WIDTH-2:0], w_take};
  assign w_rem_nxt = w_take ? w_t[WIDTH-1:0] : w_s[WIDTH-1:0];

`ifdef DIVZERO_DETECT_EN
  logic r_dz;
  assign w_start_dst = (divisor == '0) ? DONE : RUN;
  assign div_zero    = r_dz;
`else
  assign w_start_dst = RUN;
  assign div_zero    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_start_dst;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? w_start_dst : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  assign quotient  = r_quot;
  assign remainder = r_remd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_rem  <= '0;
      r_dvsr <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remd <= '0;
`ifdef DIVZERO_DETECT_EN
      r_dz   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_q    <= dividend;
      r_rem  <= '0;
      r_dvsr <= divisor;
      r_cnt  <= C_CNT_W'(WIDTH - 1);
`ifdef DIVZERO_DETECT_EN
      if (divisor == '0) begin
        r_quot <= '1;
        r_remd <= dividend;
        r_dz   <= 1'b1;
      end
`endif
    end else if (r_state == RUN) begin
      r_q   <= w_q_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - C_CNT_W'(1);
      // Results registers change only when an operation completes.
      if (w_last) begin
        r_quot <= w_q_nxt;
        r_remd <= w_rem_nxt;
`ifdef DIVZERO_DETECT_EN
        r_dz   <= 1'b0;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider (table vectors + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

  localparam int W = 16;

`ifdef DIVZERO_DETECT_EN
  localparam int   DZ_LAT  = 1;
  localparam logic DZ_FLAG = 1'b1;
`else
  localparam int   DZ_LAT  = W;
  localparam logic DZ_FLAG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient",     32'(quotient),        32'(mon_e.q));
        chk("remainder",    32'(remainder),       32'(mon_e.r));
        chk("div_zero",     32'(div_zero),        32'(mon_e.dz));
        chk("latency",      32'(cyc - mon_e.acc), 32'(mon_e.lat));
        chk("busy_at_done", 32'(busy),            32'd0);
      end
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    chk("done_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic dz, input int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{q: q, r: r, dz: dz, lat: lat, acc: cyc});
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(lat > 1));
    dividend = W'($urandom);
    divisor  = W'($urandom);
    wait_drain(W + 10);
    @(negedge clk);
    chk("hold_quotient",  32'(quotient),  32'(q));
    chk("hold_remainder", 32'(remainder), 32'(r));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{a: 16'd100,    b: 16'd7,      q: 16'd14,     r: 16'd2,      dz: 1'b0,    lat: W};
    vecs[1] = '{a: 16'hFFFF,   b: 16'd1,      q: 16'hFFFF,   r: 16'd0,      dz: 1'b0,    lat: W};
    vecs[2] = '{a: 16'd5,      b: 16'd9,      q: 16'd0,      r: 16'd5,      dz: 1'b0,    lat: W};
    vecs[3] = '{a: 16'd1000,   b: 16'd3,      q: 16'd333,    r: 16'd1,      dz: 1'b0,    lat: W};
    vecs[4] = '{a: 16'h1234,   b: 16'd0,      q: 16'hFFFF,   r: 16'h1234,   dz: DZ_FLAG, lat: DZ_LAT};
    vecs[5] = '{a: 16'd0,      b: 16'd5,      q: 16'd0,      r: 16'd0,      dz: 1'b0,    lat: W};
    vecs[6] = '{a: 16'd7,      b: 16'd7,      q: 16'd1,      r: 16'd0,      dz: 1'b0,    lat: W};
    vecs[7] = '{a: 16'hFFFF,   b: 16'hFFFF,   q: 16'd1,      r: 16'd0,      dz: 1'b0,    lat: W};
    vecs[8] = '{a: 16'h8000,   b: 16'hFFFF,   q: 16'd0,      r: 16'h8000,   dz: 1'b0,    lat: W};

    #2;
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_done",      32'(done),      32'd0);
    chk("reset_quotient",  32'(quotient),  32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_div_zero",  32'(div_zero),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);

    // start held high through RUN with changing operands
    base = done_cnt;
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{q: 16'd14, r: 16'd2, dz: 1'b0, lat: W, acc: cyc});
    for (int i = 0; i < W - 1; i++) begin
      @(negedge clk);
      dividend = W'($urandom);
      divisor  = W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain(W + 10);
    repeat (20) @(negedge clk);
    chk("held_start_done_pulses", 32'(done_cnt - base), 32'd1);

    // reset asserted mid-operation
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_done",      32'(done),      32'd0);
    chk("abort_quotient",  32'(quotient),  32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_div_zero",  32'(div_zero),  32'd0);
    base = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 10) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - base), 32'd0);
    run_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, W);

    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = (i % 2 == 1) ? W'($urandom_range(1, 300)) : W'($urandom);
      if (b == '0) b = 16'd1;
      run_op(a, b, a / b, a % b, 1'b0, W);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
